keypad_money_entry: RTL and testbench
=====================================

Name: keypad_money_entry

Overview:
- Input-side counterpart of the multiplexed 7-seg money display.
- Scans a 4x4 matrix keypad with active-low column drive and active-low row sense, debounces key presses, and builds a decimal money amount from digit keys, clamped to 0..10000.
- On the Enter key, the assembled value is presented on value_out with a one-cycle value_valid pulse.
- entry_value is live, so it can feed the display's current_money while the user is typing.

Parameters:
- SCAN_DIV, 2000: column dwell is SCAN_DIV+1 clk cycles (same refresh rate as the display mux).
- DEBOUNCE_FRAMES, 3: number of consecutive identical full-scan frames required before a key state is accepted (range 1..15).
- MAX_DIGITS, 5: maximum number of digits accepted per entry.
- MAX_VALUE, 10000: upper bound of entry_value.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  reset: asynchronous, active-high (clock is clk)
- key_row  in  4  row sense, active-low (externally pulled up); bit r = row r
- key_col  out  4  column drive, active-low, exactly one bit low at a time
- key_code  out  4  code of the last accepted key press
- key_strobe  out  1  one-cycle pulse per accepted key press
- entry_value  out  16  value currently being typed, 0..MAX_VALUE
- entry_len  out  3  number of digits accepted so far, 0..MAX_DIGITS
- value_out  out  16  last committed value
- value_valid  out  1  one-cycle pulse when value_out is updated

Behaviour:
- Reset values:
  - key_col=4'b1110 (column 0 driven).
  - All other outputs 0.
  - Scan counter, column index, debounce count and stable key are cleared; the stable key is cleared to "none".
  - An asserted reset in the middle of an entry or a press discards everything. No strobe is issued for a key that is already held when reset releases until it has been debounced as a fresh press.
- Scan timing:
  - The dwell counter counts 0..SCAN_DIV.
  - On count==SCAN_DIV: sample key_row into a frame buffer for the current column, advance the column index 0->1->2->3->0, and drive key_col=~(1<<col).
  - Sampling in the last dwell cycle gives settling time.
  - One frame = 4*(SCAN_DIV+1) clocks and ends with the column 3 sample.
- Key map (row,col -> code):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
- Frame result:
  - Exactly one low row bit across all 4 columns gives that key.
  - Zero low bits gives "none".
  - Two or more low bits (ghost/multi-press) also give "none".
- Debounce:
  - If the frame result equals the previous frame result, increment a saturating counter; otherwise reset the counter to 1.
  - When the counter reaches DEBOUNCE_FRAMES, the result becomes the stable key.
- Press event:
  - Issued only when the stable key changes from "none" to a key.
  - On the cycle after the frame-end edge, key_strobe=1 and key_code=code.
  - No auto-repeat.
  - A direct change from key X to key Y without an intervening "none" gives no event; release is required first.
- Entry update (registered, on the strobe cycle; outputs are visible on the next cycle):
  - Digit d (0..9):
    - Compute entry_value*10+d in 18 bits.
    - If entry_len<MAX_DIGITS and the result <= MAX_VALUE: entry_value=result, entry_len+1.
    - Otherwise the digit is rejected and entry_value and entry_len are unchanged.
    - Leading zeros are accepted and do increment entry_len.
  - E (*): clears entry_value and entry_len to 0.
  - F (#), entry_len>0:
    - value_out<=entry_value and value_valid=1 for one cycle.
    - entry_value and entry_len are cleared on the same edge.
  - F (#), entry_len==0: ignored, no pulse.
  - A..D: key_strobe only; no effect on the entry.
- value_valid and key_strobe are never high for two consecutive cycles.

Test Plan:
- SCAN_DIV=3, DEBOUNCE_FRAMES=3; reset, then hold row1 low only while col0 is driven (key 4) for 5 frames -> exactly one key_strobe with key_code=4; entry_value=4, entry_len=1; the strobe occurs 1 cycle after the 3rd frame end (frame=16 clocks).
- Press/release 1,2,5,0 then # -> entry_value sequence 1,12,125,1250; value_valid single pulse with value_out=1250; then entry_value=0, entry_len=0.
- Enter 9,9,9 then 9 -> the 4th digit would give 9999 (<=10000), so it is accepted; a following 9 (99999) is rejected and entry_value stays 9999. Separately, 1,0,0,0,0 gives 10000; another 0 is rejected (len=5); entry_value stays 10000.
- Bounce: key 7 toggling every frame for 6 frames, then a steady press -> no strobe during the toggling; exactly one strobe after 3 stable frames.
- Two keys held (1 and 5) -> frame result "none", no strobe; # with entry_len==0 -> no value_valid.
- Assert rst mid-entry (entry_value=37) and mid-press -> all outputs 0 and key_col=4'b1110 immediately; a key held through reset release strobes once after debounce.

Source files
------------

// File: rtl/keypad_money_entry.sv
// Keypad money entry: scans a 4x4 active-low matrix keypad, debounces whole
// scan frames, and assembles a decimal amount (0..MAX_VALUE) from digit keys.
// '*' (E) clears the entry; '#' (F) commits it to value_out with a pulse.
module keypad_money_entry #(
   parameter int SCAN_DIV        = 2000,
   parameter int DEBOUNCE_FRAMES = 3,
   parameter int MAX_DIGITS      = 5,
   parameter int MAX_VALUE       = 10000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  key_row,
   output logic [3:0]  key_col,
   output logic [3:0]  key_code,
   output logic        key_strobe,
   output logic [15:0] entry_value,
   output logic [2:0]  entry_len,
   output logic [15:0] value_out,
   output logic        value_valid
);

   localparam int              CW        = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
   localparam logic [CW-1:0]   SCAN_LAST = CW'(SCAN_DIV);
   localparam logic [3:0]      DB_N      = 4'(DEBOUNCE_FRAMES);
   localparam logic [2:0]      MAX_D     = 3'(MAX_DIGITS);
   localparam logic [17:0]     MAX_V     = 18'(MAX_VALUE);
   localparam logic [3:0]      CODE_CLR  = 4'hE;
   localparam logic [3:0]      CODE_ENT  = 4'hF;

   // Key codes indexed by col*4 + row.
   localparam logic [3:0] KEY_MAP [16] = '{
      4'h1, 4'h4, 4'h7, 4'hE,   // column 0
      4'h2, 4'h5, 4'h8, 4'h0,   // column 1
      4'h3, 4'h6, 4'h9, 4'hF,   // column 2
      4'hA, 4'hB, 4'hC, 4'hD    // column 3
   };

   typedef struct packed {
      logic       hit;    // 0 means "no key"
      logic [3:0] code;
   } key_t;

   logic [CW-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]    col_q, col_d;
   logic          scan_tick, frame_end;
   logic [11:0]   frame_q;          // row samples of columns 0..2
   logic [15:0]   low_bits;
   key_t          frame_key;
   key_t          prev_q, prev_d, stable_q, stable_d;
   logic [3:0]    db_cnt_q, db_cnt_d;
   logic          press;
   logic          strobe_q;
   logic [3:0]    code_q;
   logic [15:0]   entry_q, entry_d, vout_q, vout_d;
   logic [2:0]    len_q, len_d;
   logic          vvalid_q, vvalid_d;
   logic [17:0]   cand;

   // Dwell counter and column sequencing.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      scan_tick  = (scan_cnt_q == SCAN_LAST);
      frame_end  = scan_tick && (col_q == 2'd3);
      scan_cnt_d = scan_tick ? '0 : scan_cnt_q + 1'b1;
      col_d      = scan_tick ? col_q + 2'd1 : col_q;
   end

   // Scan state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
         scan_cnt_q <= '0;
         col_q      <= 2'd0;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         col_q      <= col_d;
      end
   end

   // Frame buffer: capture the rows in the last dwell cycle of columns 0..2.
   // NOTE: no reset here; every entry is rewritten before the frame that reads it ends.
   always_ff @(posedge clk) begin
      if (scan_tick) begin
         case (col_q)
            2'd0:    frame_q[3:0]  <= key_row;
            2'd1:    frame_q[7:4]  <= key_row;
            2'd2:    frame_q[11:8] <= key_row;
            default: ;
         endcase
      end
   end

   // Frame result (column 3 taken live) and debounce decision.
   always_comb begin
      low_bits  = ~{key_row, frame_q};
      frame_key = '0;
      if ($countones(low_bits) == 1) begin
         for (int i = 0; i < 16; i++) begin
            if (low_bits[i]) frame_key = '{hit: 1'b1, code: KEY_MAP[i]};
         end
      end
      prev_d   = prev_q;
      db_cnt_d = db_cnt_q;
      stable_d = stable_q;
      press    = 1'b0;
      if (frame_end) begin
         prev_d = frame_key;
         if (frame_key == prev_q) db_cnt_d = (db_cnt_q == 4'hF) ? 4'hF : db_cnt_q + 4'd1;
         else                     db_cnt_d = 4'd1;
         if (db_cnt_d >= DB_N) stable_d = frame_key;
         press = !stable_q.hit && stable_d.hit;
      end
   end

   // Debounce state and press strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q   <= '0;
         stable_q <= '0;
         db_cnt_q <= 4'd0;
         strobe_q <= 1'b0;
         code_q   <= 4'd0;
      end else begin
         prev_q   <= prev_d;
         stable_q <= stable_d;
         db_cnt_q <= db_cnt_d;
         strobe_q <= press;
         if (press) code_q <= stable_d.code;
      end
   end

   // Entry update on the strobe cycle.
   always_comb begin
      cand     = {2'b00, entry_q} * 18'd10 + {14'b0, code_q};
      entry_d  = entry_q;
      len_d    = len_q;
      vout_d   = vout_q;
      vvalid_d = 1'b0;
      if (strobe_q) begin
         if (code_q <= 4'd9) begin
            if ((len_q < MAX_D) && (cand <= MAX_V)) begin
               entry_d = cand[15:0];
               len_d   = len_q + 3'd1;
            end
         end else if (code_q == CODE_CLR) begin
            entry_d = '0;
            len_d   = '0;
         end else if ((code_q == CODE_ENT) && (len_q != 3'd0)) begin
            vout_d   = entry_q;
            vvalid_d = 1'b1;
            entry_d  = '0;
            len_d    = '0;
         end
      end
   end

   // Entry and committed-value registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry_q  <= '0;
         len_q    <= '0;
         vout_q   <= '0;
         vvalid_q <= 1'b0;
      end else begin
         entry_q  <= entry_d;
         len_q    <= len_d;
         vout_q   <= vout_d;
         vvalid_q <= vvalid_d;
      end
   end

   assign key_col     = ~(4'b0001 << col_q);
   assign key_code    = code_q;
   assign key_strobe  = strobe_q;
   assign entry_value = entry_q;
   assign entry_len   = len_q;
   assign value_out   = vout_q;
   assign value_valid = vvalid_q;

endmodule

// File: tb/tb_keypad_money_entry.sv
// Bench for keypad_money_entry: a keypad model drives the rows from the held
// key set; a frame-level reference model predicts press events, entry values
// and commits into queues that a negedge monitor pops and compares.
module tb_keypad_money_entry;

   localparam int SCAN_DIV = 3;
   localparam int DB       = 3;
   localparam int FRAME    = 4 * (SCAN_DIV + 1);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  key_row;
   logic [3:0]  key_col;
   logic [3:0]  key_code;
   logic        key_strobe;
   logic [15:0] entry_value;
   logic [2:0]  entry_len;
   logic [15:0] value_out;
   logic        value_valid;

   keypad_money_entry #(
      .SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DB), .MAX_DIGITS(5), .MAX_VALUE(10000)
   ) dut (
      .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col),
      .key_code(key_code), .key_strobe(key_strobe),
      .entry_value(entry_value), .entry_len(entry_len),
      .value_out(value_out), .value_valid(value_valid)
   );

   always #5 clk = ~clk;

   // Held keys, bit r*4+c; layout gives the key legend at that position.
   logic [15:0] pressed = '0;
   int layout [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

   always_comb begin
      key_row = 4'hF;
      for (int r = 0; r < 4; r++)
         if (|(pressed[r*4 +: 4] & ~key_col)) key_row[r] = 1'b0;
   end

   int cyc;
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int code;
      int cyc;
      int val;
      int len;
      bit commit;
   } ev_t;

   ev_t evq[$];
   int  vq[$];
   int  m_prev = -1, m_cnt = 0, m_stable = -1, m_val = 0, m_len = 0, m_frame = 0;

   function automatic void apply_key(int code);
      ev_t e;
      e.code   = code;
      e.cyc    = FRAME * m_frame;
      e.commit = 1'b0;
      if (code <= 9) begin
         if (m_len < 5 && m_val * 10 + code <= 10000) begin
            m_val = m_val * 10 + code;
            m_len++;
         end
      end else if (code == 14) begin
         m_val = 0; m_len = 0;
      end else if (code == 15 && m_len > 0) begin
         vq.push_back(m_val);
         e.commit = 1'b1;
         m_val = 0; m_len = 0;
      end
      e.val = m_val;
      e.len = m_len;
      evq.push_back(e);
   endfunction

   function automatic void model_frame();
      int res = -1;
      if ($countones(pressed) == 1)
         for (int i = 0; i < 16; i++) if (pressed[i]) res = layout[i];
      m_frame++;
      if (res == m_prev) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      else               m_cnt = 1;
      m_prev = res;
      if (m_cnt >= DB) begin
         if (m_stable == -1 && res != -1) apply_key(res);
         m_stable = res;
      end
   endfunction

   function automatic logic [15:0] kbit(int code);
      logic [15:0] b = '0;
      for (int i = 0; i < 16; i++) if (layout[i] == code) b[i] = 1'b1;
      return b;
   endfunction

   // ---------------- stimulus helpers ----------------
   // Called at the negedge after a frame end; returns at the next such negedge.
   task automatic hold(input logic [15:0] keys, input int frames);
      pressed = keys;
      for (int f = 0; f < frames; f++) begin
         model_frame();
         repeat (FRAME) @(posedge clk);
      end
      @(negedge clk);
   endtask

   task automatic press_key(input int code);
      hold(kbit(code), 4);
      hold('0, 3);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_key_col", key_col, 4'b1110);
      check("rst_key_code", key_code, 0);
      check("rst_key_strobe", key_strobe, 0);
      check("rst_entry_value", entry_value, 0);
      check("rst_entry_len", entry_len, 0);
      check("rst_value_out", value_out, 0);
      check("rst_value_valid", value_valid, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_prev = -1; m_cnt = 0; m_stable = -1; m_val = 0; m_len = 0; m_frame = 0;
      evq.delete();
      vq.delete();
   endtask

   // ---------------- monitor ----------------
   ev_t pend;
   bit  pend_v = 1'b0;
   bit  prev_strobe = 1'b0;
   bit  prev_vv = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         pend_v = 1'b0; prev_strobe = 1'b0; prev_vv = 1'b0;
      end else begin
         if (pend_v) begin
            check("entry_value", entry_value, pend.val);
            check("entry_len", entry_len, pend.len);
            check("value_valid_pulse", value_valid, pend.commit);
            pend_v = 1'b0;
         end
         if (value_valid) begin
            check("value_valid_expected", vq.size() > 0, 1);
            check("value_valid_single", prev_vv, 0);
            if (vq.size() > 0) check("value_out", value_out, vq.pop_front());
         end
         if (key_strobe) begin
            check("strobe_single", prev_strobe, 0);
            check("strobe_expected", evq.size() > 0, 1);
            if (evq.size() > 0) begin
               pend = evq.pop_front();
               check("key_code", key_code, pend.code);
               check("strobe_cycle", cyc, pend.cyc);
               pend_v = 1'b1;
            end
         end
         prev_strobe = key_strobe;
         prev_vv     = value_valid;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: run did not finish");
      $fatal(1);
   end

   // ---------------- test sequence ----------------
   initial begin
      int sel, code, code2;
      do_reset();

      // Key 4 held 5 frames: one strobe after the 3rd frame end.
      hold(kbit(4), 5);
      check("k4_entry_value", entry_value, 4);
      check("k4_entry_len", entry_len, 1);
      hold('0, 3);
      press_key(14);

      // 1,2,5,0 then # commits 1250.
      press_key(1); press_key(2); press_key(5); press_key(0);
      press_key(15);
      check("commit_value_out", value_out, 1250);
      check("commit_entry_cleared", entry_value, 0);

      // 9999 accepted, 99999 rejected.
      press_key(9); press_key(9); press_key(9); press_key(9); press_key(9);
      check("clamp_9999", entry_value, 9999);
      check("clamp_9999_len", entry_len, 4);
      press_key(14);
      press_key(1); press_key(0); press_key(0); press_key(0); press_key(0); press_key(0);
      check("max_10000", entry_value, 10000);
      check("max_10000_len", entry_len, 5);
      press_key(14);

      // Bounce on key 7, then a steady press.
      for (int i = 0; i < 3; i++) begin
         hold(kbit(7), 1);
         hold('0, 1);
      end
      press_key(7);

      // Ghost press, then # with an empty entry.
      press_key(15);
      hold(kbit(1) | kbit(5), 4);
      hold('0, 3);
      press_key(15);

      // Reset mid-entry (37) and mid-press, with key 5 held through release.
      press_key(3); press_key(7);
      check("pre_reset_37", entry_value, 37);
      hold(kbit(5), 1);
      check("pre_reset_strobes_drained", evq.size(), 0);
      do_reset();
      hold(kbit(5), 4);
      hold('0, 3);
      check("post_reset_entry", entry_value, 5);

      // Randomised phase.
      for (int n = 0; n < 40; n++) begin
         sel  = $urandom_range(0, 9);
         code = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
         if (sel < 7) begin
            hold(kbit(code), $urandom_range(3, 5));
            hold('0, $urandom_range(3, 4));
         end else if (sel == 7) begin
            hold(kbit(code), 1);
            hold('0, 1);
         end else if (sel == 8) begin
            code2 = $urandom_range(0, 15);
            hold(kbit(code) | kbit(code2), 3);
            hold('0, 3);
         end else begin
            hold(kbit(code), 2);
            hold('0, 1);
            hold(kbit(code), 3);
            hold('0, 3);
         end
      end

      hold('0, 3);
      repeat (4) @(negedge clk);
      check("strobe_queue_empty", evq.size(), 0);
      check("value_queue_empty", vq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
